// File: rtl/square_cube_root_unit.sv
// Iterative integer square root and cube root of a 32-bit operand.
// One result bit per cycle; results and done are registered 16 cycles after start is accepted.
module square_cube_root_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] number,
    output logic [15:0] sq_root,
    output logic [10:0] cube_root,
    output logic        busy,
    output logic        done
);

    typedef enum logic {StIdle, StCalc} state_e;

    state_e      state_q, state_d;
    logic [3:0]  iter_q, iter_d;
    logic [31:0] num_q, num_d;
    logic [31:0] rad_q, rad_d;
    logic [19:0] rem_q, rem_d;
    logic [15:0] root_q, root_d;
    logic [10:0] cube_q, cube_d;
    logic [15:0] sq_root_q, sq_root_d;
    logic [10:0] cube_root_q, cube_root_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Square root datapath: restoring digit-by-digit, two radicand bits per step.
    logic [19:0] rem_shift;
    logic [19:0] sq_trial;
    logic        sq_fit;
    logic [19:0] rem_next;
    logic [15:0] root_next;

    assign rem_shift = {rem_q[17:0], rad_q[31:30]};
    assign sq_trial  = {2'b00, root_q, 2'b01};
    assign sq_fit    = (rem_shift >= sq_trial);
    assign rem_next  = sq_fit ? (rem_shift - sq_trial) : rem_shift;
    assign root_next = {root_q[14:0], sq_fit};

    // Cube root datapath: trial-and-keep on bits 10..0; 34 bits holds 2047^3 without overflow.
    logic [10:0] cube_bit;
    logic [10:0] cube_trial;
    logic [33:0] cube_trial_w;
    logic [33:0] cube_pow;
    logic        cube_fit;
    logic [10:0] cube_next;

    assign cube_bit     = (iter_q <= 4'd10) ? (11'd1 << (4'd10 - iter_q)) : 11'd0;
    assign cube_trial   = cube_q | cube_bit;
    assign cube_trial_w = {23'd0, cube_trial};
    assign cube_pow     = cube_trial_w * cube_trial_w * cube_trial_w;
    assign cube_fit     = (cube_bit != 11'd0) && (cube_pow <= {2'b00, num_q});
    assign cube_next    = cube_fit ? cube_trial : cube_q;

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        num_d       = num_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cube_d      = cube_q;
        sq_root_d   = sq_root_q;
        cube_root_d = cube_root_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d   = number;
                    rad_d   = number;
                    rem_d   = 20'd0;
                    root_d  = 16'd0;
                    cube_d  = 11'd0;
                    iter_d  = 4'd0;
                    busy_d  = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                rad_d  = {rad_q[29:0], 2'b00};
                rem_d  = rem_next;
                root_d = root_next;
                cube_d = cube_next;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    sq_root_d   = root_next;
                    cube_root_d = cube_next;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            iter_q      <= 4'd0;
            num_q       <= 32'd0;
            rad_q       <= 32'd0;
            rem_q       <= 20'd0;
            root_q      <= 16'd0;
            cube_q      <= 11'd0;
            sq_root_q   <= 16'd0;
            cube_root_q <= 11'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            num_q       <= num_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cube_q      <= cube_d;
            sq_root_q   <= sq_root_d;
            cube_root_q <= cube_root_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sq_root   = sq_root_q;
    assign cube_root = cube_root_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_square_cube_root_unit.sv
// Directed and randomized checks for square_cube_root_unit: reset, known roots,
// boundaries, start-ignore during CALC, mid-run reset and back-to-back operation.
module tb_square_cube_root_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] number;
    logic [15:0] sq_root;
    logic [10:0] cube_root;
    logic        busy;
    logic        done;

    int vec_cnt = 0;
    int err_cnt = 0;

    square_cube_root_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .number    (number),
        .sq_root   (sq_root),
        .cube_root (cube_root),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic bit sq_ok(input logic [31:0] n, input logic [15:0] s);
        longint unsigned a = 64'(s);
        longint unsigned v = 64'(n);
        return (a * a <= v) && ((a + 1) * (a + 1) > v);
    endfunction

    function automatic bit cb_ok(input logic [31:0] n, input logic [10:0] c);
        longint unsigned a = 64'(c);
        longint unsigned v = 64'(n);
        return (a * a * a <= v) && ((a + 1) * (a + 1) * (a + 1) > v);
    endfunction

    // Pulses start for one edge and waits (bounded) for done; lat counts edges after acceptance.
    task automatic run_op(input logic [31:0] n, output logic [15:0] sq, output logic [10:0] cb,
                          output int lat);
        @(negedge clk);
        number = n;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        sq = sq_root;
        cb = cube_root;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        start  = 1'b0;
        number = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({sq_root, cube_root, busy, done} !== 29'd0) begin
            err_cnt++;
            $display("FAIL reset: sq=%0d cube=%0d busy=%b done=%b, required all 0",
                     sq_root, cube_root, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] nums [10] = '{0, 1, 8, 16, 27, 50, 64, 100, 125, 1000};
        logic [15:0] sqs  [10] = '{0, 1, 2, 4, 5, 7, 8, 10, 11, 31};
        logic [10:0] cbs  [10] = '{0, 1, 2, 2, 3, 3, 4, 4, 5, 10};
        logic [15:0] sq;
        logic [10:0] cb;
        int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(nums[i], sq, cb, lat);
            vec_cnt++;
            if (sq !== sqs[i] || cb !== cbs[i] || lat != 16) begin
                err_cnt++;
                $display("FAIL directed n=%0d: sq=%0d cube=%0d lat=%0d, required %0d/%0d lat=16",
                         nums[i], sq, cb, lat, sqs[i], cbs[i]);
            end
        end
    endtask

    task automatic test_boundary;
        logic [31:0] nums [3] = '{32'hFFFF_FFFF, 32'd4291015624, 32'd4291015625};
        logic [15:0] sqs  [3] = '{16'd65535, 16'd65505, 16'd65505};
        logic [10:0] cbs  [3] = '{11'd1625, 11'd1624, 11'd1625};
        logic [15:0] sq;
        logic [10:0] cb;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(nums[i], sq, cb, lat);
            vec_cnt++;
            if (sq !== sqs[i] || cb !== cbs[i] || lat != 16) begin
                err_cnt++;
                $display("FAIL boundary n=%0d: sq=%0d cube=%0d lat=%0d, required %0d/%0d lat=16",
                         nums[i], sq, cb, lat, sqs[i], cbs[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int          done_cnt = 0;
        int          done_at  = -1;
        logic [15:0] sq = '0;
        logic [10:0] cb = '0;
        @(negedge clk);
        number = 32'd1000;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 3) begin
                number = 32'd64;
                start  = 1'b1;
            end
            if (c == 4) start = 1'b0;
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_at = c;
                sq      = sq_root;
                cb      = cube_root;
            end
        end
        vec_cnt++;
        if (done_cnt != 1 || done_at != 16 || sq !== 16'd31 || cb !== 11'd10) begin
            err_cnt++;
            $display("FAIL ignore_start: dones=%0d at=%0d sq=%0d cube=%0d, required 1 at 16 31/10",
                     done_cnt, done_at, sq, cb);
        end
    endtask

    task automatic test_reset_mid;
        int          done_cnt = 0;
        logic [15:0] sq;
        logic [10:0] cb;
        int          lat;
        @(negedge clk);
        number = 32'd100;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || sq_root !== 16'd0 || cube_root !== 11'd0) begin
            err_cnt++;
            $display("FAIL reset_mid: busy=%b done=%b sq=%0d cube=%0d, required all 0",
                     busy, done, sq_root, cube_root);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        vec_cnt++;
        if (done_cnt != 0) begin
            err_cnt++;
            $display("FAIL reset_mid_no_done: dones=%0d, required 0", done_cnt);
        end
        run_op(32'd27, sq, cb, lat);
        vec_cnt++;
        if (sq !== 16'd5 || cb !== 11'd3 || lat != 16) begin
            err_cnt++;
            $display("FAIL reset_mid_restart: sq=%0d cube=%0d lat=%0d, required 5/3 lat=16",
                     sq, cb, lat);
        end
    endtask

    function automatic logic [31:0] gen_num(input int i);
        logic [31:0] c;
        logic [31:0] s;
        case (i % 4)
            0: return $urandom;
            1: return $urandom_range(0, 5000);
            2: begin
                c = $urandom_range(1, 1625);
                return c * c * c + $urandom_range(0, 2) - 32'd1;
            end
            default: begin
                s = $urandom_range(1, 65535);
                return s * s - $urandom_range(0, 1);
            end
        endcase
    endfunction

    task automatic test_back_to_back;
        logic [31:0] prev;
        int          lat;
        prev = gen_num(0);
        @(negedge clk);
        number = prev;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        for (int i = 0; i < 1000; i++) begin
            while (!done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            vec_cnt++;
            if (lat != 16 || !sq_ok(prev, sq_root) || !cb_ok(prev, cube_root)) begin
                err_cnt++;
                $display("FAIL back_to_back #%0d n=%0d: sq=%0d cube=%0d lat=%0d, required floors lat=16",
                         i, prev, sq_root, cube_root, lat);
                if (lat >= 40) break;
            end
            if (i < 999) begin
                prev   = gen_num(i + 1);
                number = prev;
                start  = 1'b1;
                @(negedge clk);
                start = 1'b0;
                lat   = 0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_boundary;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
